// File: rtl/beat_period_meter.sv
`default_nettype none
// ============================================================================
// Module   : beat_period_meter
// Brief    : Measures clock cycles between rising edges of a beat strobe,
//            reports each period, flags lock on a stable period and pulses
//            timeout when beats stop arriving.
// Revision : 1.0 - initial release
// ============================================================================
module beat_period_meter #(
    parameter int WIDTH      = 16,
    parameter int TIMEOUT    = 65000,
    parameter int TOL        = 2,
    parameter int LOCK_COUNT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             beat_in,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    localparam int              c_MW      = $clog2(LOCK_COUNT + 1);
    localparam logic [WIDTH-1:0] c_TIMEOUT = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] c_ONE     = WIDTH'(1);
    localparam logic [WIDTH:0]   c_TOL     = (WIDTH+1)'(TOL);
    localparam logic [c_MW-1:0]  c_LOCK    = c_MW'(LOCK_COUNT);
    localparam logic [c_MW-1:0]  c_MONE    = c_MW'(1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_FIRST   = 2'd1;
    localparam logic [1:0] c_MEASURE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_cnt;
    logic             r_beat_d;
    logic [c_MW-1:0]  r_match;

    logic             w_edge;
    logic             w_load;
    logic             w_tmo_hit;
    logic [WIDTH:0]   w_cnt_x;
    logic [WIDTH:0]   w_per_x;
    logic [WIDTH:0]   w_diff;
    logic             w_match_ok;
    logic [c_MW-1:0]  w_match_inc;

    assign w_edge = beat_in & ~r_beat_d;

    // Distance of the new interval from the previous period, one bit wider so
    // the subtraction cannot wrap.
    assign w_cnt_x     = {1'b0, r_cnt};
    assign w_per_x     = {1'b0, period};
    assign w_diff      = (r_cnt >= period) ? (w_cnt_x - w_per_x) : (w_per_x - w_cnt_x);
    assign w_match_ok  = (w_diff <= c_TOL);
    assign w_match_inc = (r_match == c_LOCK) ? r_match : (r_match + c_MONE);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; a beat edge always beats a coincident timeout
    always_comb begin
        w_state_nxt = r_state;
        if (en) begin
            case (r_state)
                c_IDLE: begin
                    if (w_edge) begin
                        w_state_nxt = c_FIRST;
                    end
                end
                c_FIRST, c_MEASURE: begin
                    if (w_load) begin
                        w_state_nxt = c_MEASURE;
                    end else if (w_tmo_hit) begin
                        w_state_nxt = c_IDLE;
                    end
                end
                default: w_state_nxt = c_IDLE;
            endcase
        end
    end

    // Action decode: load a new period on an edge, or time out at the limit
    always_comb begin
        w_load    = 1'b0;
        w_tmo_hit = 1'b0;
        if (en && (r_state == c_FIRST || r_state == c_MEASURE)) begin
            if (w_edge) begin
                w_load = 1'b1;
            end else if (r_cnt == c_TIMEOUT) begin
                w_tmo_hit = 1'b1;
            end
        end
    end

    // Interval counter, registered outputs and lock tracking; frozen while en=0
    always_ff @(posedge clk) begin
        if (reset) begin
            r_beat_d     <= 1'b0;
            r_cnt        <= '0;
            r_match      <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
        end else if (en) begin
            r_beat_d     <= beat_in;
            period_valid <= w_load;
            timeout      <= w_tmo_hit;

            if (r_state == c_IDLE) begin
                r_cnt <= w_edge ? c_ONE : '0;
            end else if (w_load) begin
                r_cnt <= c_ONE;
            end else if (w_tmo_hit) begin
                r_cnt <= '0;
            end else if (r_cnt != c_TIMEOUT) begin
                r_cnt <= r_cnt + c_ONE;
            end

            if (w_load) begin
                period <= r_cnt;
                if (r_state == c_FIRST) begin
                    // First interval has nothing to compare against
                    r_match <= '0;
                end else if (w_match_ok) begin
                    r_match <= w_match_inc;
                    locked  <= (w_match_inc == c_LOCK);
                end else begin
                    r_match <= '0;
                    locked  <= 1'b0;
                end
            end else if (w_tmo_hit) begin
                r_match <= '0;
                locked  <= 1'b0;
            end
        end else begin
            period_valid <= 1'b0;
            timeout      <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_beat_period_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_beat_period_meter
// Brief    : Directed self-checking bench for beat_period_meter with a
//            behavioural reference model compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_beat_period_meter;

    localparam int c_WIDTH   = 16;
    localparam int c_TIMEOUT = 3000;
    localparam int c_TOL     = 2;
    localparam int c_LOCK    = 4;

    logic                clk;
    logic                reset;
    logic                en;
    logic                beat_in;
    logic [c_WIDTH-1:0]  period;
    logic                period_valid;
    logic                locked;
    logic                timeout;

    int checks = 0;
    int errors = 0;

    // Snapshot of outputs one cycle after a beat's rising edge
    int s_pv, s_per, s_lk, s_to;

    beat_period_meter #(
        .WIDTH      (c_WIDTH),
        .TIMEOUT    (c_TIMEOUT),
        .TOL        (c_TOL),
        .LOCK_COUNT (c_LOCK)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .beat_in      (beat_in),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: counts enabled cycles since the last beat, keeps a
    // streak of consecutive in-tolerance periods and derives the outputs.
    int  m_since, m_period, m_streak;
    bit  m_prev, m_armed, m_measuring, m_locked, m_pv, m_to;

    always @(posedge clk) begin
        bit e;
        int d;
        if (reset) begin
            m_prev = 0; m_armed = 0; m_measuring = 0; m_since = 0;
            m_period = 0; m_streak = 0; m_locked = 0; m_pv = 0; m_to = 0;
        end else if (!en) begin
            m_pv = 0;
            m_to = 0;
        end else begin
            e = beat_in && !m_prev;
            m_prev = beat_in;
            m_pv = 0;
            m_to = 0;
            if (e) begin
                if (m_armed) begin
                    if (m_measuring) begin
                        d = (m_since > m_period) ? m_since - m_period : m_period - m_since;
                        if (d <= c_TOL) m_streak = m_streak + 1;
                        else            m_streak = 0;
                    end else begin
                        m_streak = 0;
                    end
                    m_locked    = (m_streak >= c_LOCK);
                    m_period    = m_since;
                    m_pv        = 1;
                    m_measuring = 1;
                end
                m_armed = 1;
                m_since = 1;
            end else if (m_armed) begin
                if (m_since == c_TIMEOUT) begin
                    m_to = 1; m_locked = 0; m_streak = 0;
                    m_armed = 0; m_measuring = 0;
                end else begin
                    m_since = m_since + 1;
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, sampled on the falling edge
    task automatic compare_loop();
        forever begin
            @(negedge clk);
            check("model_period",       int'(period),       m_period);
            check("model_period_valid", int'(period_valid), int'(m_pv));
            check("model_locked",       int'(locked),       int'(m_locked));
            check("model_timeout",      int'(timeout),      int'(m_to));
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Raise beat_in for hi cycles; next rising edge comes interval cycles later
    task automatic beat(input int hi, input int interval);
        beat_in = 1'b1;
        @(negedge clk);
        s_pv  = int'(period_valid);
        s_per = int'(period);
        s_lk  = int'(locked);
        s_to  = int'(timeout);
        wait_cyc(hi - 1);
        beat_in = 1'b0;
        wait_cyc(interval - hi);
    endtask

    initial begin
        reset   = 1'b1;
        en      = 1'b1;
        beat_in = 1'b0;
        fork
            compare_loop();
        join_none
        wait_cyc(2);
        reset = 1'b0;
        check("reset_period", int'(period), 0);
        check("reset_pv",     int'(period_valid), 0);
        check("reset_locked", int'(locked), 0);
        check("reset_timeout", int'(timeout), 0);

        // Steady 1000-cycle ticks: lock on the sixth beat
        beat(1, 1000); check("b1_no_pv", s_pv, 0);
        beat(1, 1000); check("b2_pv", s_pv, 1); check("b2_period", s_per, 1000);
        check("b2_unlocked", s_lk, 0);
        beat(1, 1000);
        beat(1, 1000);
        beat(1, 1000); check("b5_unlocked", s_lk, 0);
        beat(1, 1000); check("b6_locked", s_lk, 1); check("b6_period", s_per, 1000);

        // Jitter within tolerance keeps lock; a 3-cycle step drops it
        beat(1, 1002); check("b7_period", s_per, 1000);
        beat(1, 1000); check("b8_period", s_per, 1002); check("b8_locked", s_lk, 1);
        beat(1, 1003); check("b9_period", s_per, 1000); check("b9_locked", s_lk, 1);
        beat(1, 1001); check("b10_pv", s_pv, 1); check("b10_period", s_per, 1003);
        check("b10_unlocked", s_lk, 0);
        beat(1, 1000); check("b11_period", s_per, 1001);
        beat(1, 1000);
        beat(1, 1000); check("b13_unlocked", s_lk, 0);
        beat(1, 1);    check("b14_relocked", s_lk, 1);

        // Beats stop: timeout pulse exactly TIMEOUT cycles after the last edge
        wait_cyc(c_TIMEOUT - 1);
        check("tmo_not_early", int'(timeout), 0);
        wait_cyc(1);
        check("tmo_pulse", int'(timeout), 1);
        check("tmo_unlock", int'(locked), 0);
        check("tmo_period_held", int'(period), 1000);
        wait_cyc(1);
        check("tmo_single", int'(timeout), 0);
        wait_cyc(10);
        beat(1, 1000); check("b15_no_pv", s_pv, 0);
        beat(1, 1000); check("b16_pv", s_pv, 1); check("b16_period", s_per, 1000);

        // 50 disabled cycles inside a 1000-cycle gap
        beat(1, 1); check("b17_period", s_per, 1000);
        wait_cyc(400);
        en = 1'b0;
        wait_cyc(50);
        check("en_low_period_held", int'(period), 1000);
        check("en_low_no_pv", int'(period_valid), 0);
        en = 1'b1;
        wait_cyc(549);
        beat(1, 300); check("b18_pv", s_pv, 1); check("b18_period", s_per, 950);

        // Single-cycle reset mid-interval
        reset = 1'b1;
        wait_cyc(1);
        check("mid_reset_period", int'(period), 0);
        check("mid_reset_locked", int'(locked), 0);
        check("mid_reset_pv", int'(period_valid), 0);
        reset = 1'b0;
        beat(1, 1000); check("b19_no_pv", s_pv, 0);
        beat(1, 1000); check("b20_pv", s_pv, 1); check("b20_period", s_per, 1000);

        // Wide beats count once; an edge exactly at the limit is a period
        beat(5, 1000); check("b21_period", s_per, 1000);
        beat(5, 1000); check("b22_pv", s_pv, 1);
        beat(5, c_TIMEOUT); check("b23_period", s_per, 1000);
        beat(5, 10);
        check("edge_at_limit_pv", s_pv, 1);
        check("edge_at_limit_period", s_per, c_TIMEOUT);
        check("edge_at_limit_no_tmo", s_to, 0);
        wait_cyc(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
